// File: rtl/logical_unit_pkg.sv
// Shared definitions for the iterative logical unit: op encodings, FSM states
// and default geometry.
package logical_unit_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CHUNK = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ANDN = 3'b011,
    OP_ORN  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit op_is_reserved(input logic [2:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/logical_unit_iter_if.sv
// Request/response handshake bundle between a requester and logical_unit_iter.
interface logical_unit_iter_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/logical_chunk.sv
// Combinational bitwise function on one CHUNK-wide slice; reserved op yields 0.
module logical_chunk
  import logical_unit_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [2:0]       op,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logical_unit_iter.sv
// Iterative logical unit: captures operands, then produces the result one
// CHUNK-wide slice per cycle, lowest slice first.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | computing slice cnt of the captured operands
// DONE  | result held with out_valid=1 until out_ready
module logical_unit_iter
  import logical_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input logic               clk,
  input logic               rst,
  logical_unit_iter_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic             out_valid_q;

  logic             in_ready_c;
  logic             accept;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] y_chunk;

  assign a_chunk = a_q[int'(cnt) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(cnt) * CHUNK +: CHUNK];

  logical_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .op (op_q),
    .y  (y_chunk)
  );

  // In DONE the slot frees on the same edge the result is consumed, so a new
  // request can be taken without a bubble.
  always_comb begin
    in_ready_c = 1'b0;
    case (state)
      IDLE:    in_ready_c = 1'b1;
      BUSY:    in_ready_c = 1'b0;
      DONE:    in_ready_c = bus.out_ready;
      default: in_ready_c = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          result_q[int'(cnt) * CHUNK +: CHUNK] <= y_chunk;
          zero_q <= zero_q & ~(|y_chunk);
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            illegal_q   <= op_is_reserved(op_q);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept overrides the DONE->IDLE transition above for back-to-back ops.
      if (accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        op_q      <= bus.op;
        cnt       <= '0;
        result_q  <= '0;
        zero_q    <= 1'b1;
        illegal_q <= 1'b0;
        state     <= BUSY;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_logical_unit_iter.sv
// Scoreboard bench for logical_unit_iter: a 16-bit-chunk instance and a
// single-chunk instance sharing clock and reset.
module tb_logical_unit_iter;

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        il;
  } exp_t;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];
  exp_t sb64[$];
  exp_t exp_last;

  logical_unit_iter_if #(.WIDTH(64)) u_if ();
  logical_unit_iter_if #(.WIDTH(64)) u_if64 ();

  logical_unit_iter #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  logical_unit_iter #(.WIDTH(64), .CHUNK(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (u_if64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_fn(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a & ~b;
      3'd4: return a | ~b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    exp_t e;
    e.r  = ref_fn(op, a, b);
    e.z  = (e.r == 64'd0);
    e.il = (op == 3'd7);
    return e;
  endfunction

  // Called at a negedge while the DUT is idle (or in DONE with out_ready=1).
  task automatic send(input string name, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    u_if.in_valid = 1'b1;
    u_if.op       = op;
    u_if.a        = a;
    u_if.b        = b;
    sb.push_back(make_exp(op, a, b));
    #1;
    compared++;
    if (u_if.in_ready !== 1'b1) begin
      $display("FAIL %s in_ready before accept: got %b want 1", name, u_if.in_ready);
      mismatched++;
    end
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.op       = 3'($urandom_range(0, 7));
    u_if.a        = {$urandom, $urandom};
    u_if.b        = {$urandom, $urandom};
  endtask

  task automatic wait_result(input string name, input int lat);
    int cycles = 0;
    bit seen = 0;
    while (!seen && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (u_if.out_valid === 1'b1) seen = 1;
    end
    compared++;
    if (!seen) begin
      $display("FAIL %s timeout: no out_valid after %0d cycles", name, cycles);
      mismatched++;
      return;
    end
    if (cycles !== lat) begin
      $display("FAIL %s latency: got %0d want %0d", name, cycles, lat);
      mismatched++;
    end
    compared++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: got out_valid want no result pending", name);
      mismatched++;
      return;
    end
    exp_last = sb.pop_front();
    compared++;
    if (u_if.result !== exp_last.r) begin
      $display("FAIL %s result: got %h want %h", name, u_if.result, exp_last.r);
      mismatched++;
    end
    compared++;
    if (u_if.zero !== exp_last.z) begin
      $display("FAIL %s zero: got %b want %b", name, u_if.zero, exp_last.z);
      mismatched++;
    end
    compared++;
    if (u_if.illegal !== exp_last.il) begin
      $display("FAIL %s illegal: got %b want %b", name, u_if.illegal, exp_last.il);
      mismatched++;
    end
  endtask

  task automatic run_basic(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b);
    @(negedge clk);
    @(negedge clk);
    send(name, op, a, b);
    wait_result(name, 4);
    @(negedge clk);
    compared++;
    if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", name,
               u_if.out_valid, u_if.in_ready);
      mismatched++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    compared++;
    if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.result !== 64'd0 ||
        u_if.zero !== 1'b0 || u_if.illegal !== 1'b0) begin
      $display("FAIL reset: got rdy=%b ov=%b res=%h z=%b il=%b want 1 0 0 0 0",
               u_if.in_ready, u_if.out_valid, u_if.result, u_if.zero, u_if.illegal);
      mismatched++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ops();
    run_basic("xor", 3'd2, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F);
    compared++;
    if (exp_last.r !== 64'hF0F00F0FF0F00F0F) begin
      $display("FAIL xor model: got %h want F0F00F0FF0F00F0F", exp_last.r);
      mismatched++;
    end
    run_basic("andn_zero", 3'd3, 64'h00000000000000FF, 64'h00000000000000FF);
    run_basic("reserved", 3'd7, 64'h123456789ABCDEF0, 64'hCAFEF00DDEADBEEF);
    run_basic("orn", 3'd4, 64'h00FF00FF00FF00FF, 64'hF0F0F0F0F0F0F0F0);
    run_basic("xnor", 3'd5, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    for (int i = 0; i < 4; i++) begin
      logic [2:0]  op_r;
      logic [63:0] a_r;
      logic [63:0] b_r;
      op_r = 3'($urandom_range(0, 7));
      a_r  = {$urandom, $urandom};
      b_r  = {$urandom, $urandom};
      run_basic("random", op_r, a_r, b_r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    send("stall", 3'd0, 64'hFFFF_FFFF_0000_FFFF, 64'h1234_5678_9ABC_DEF0);
    wait_result("stall", 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      compared++;
      if (u_if.result !== exp_last.r || u_if.out_valid !== 1'b1 || u_if.in_ready !== 1'b0) begin
        $display("FAIL stall hold %0d: got res=%h ov=%b rdy=%b want %h 1 0", i,
                 u_if.result, u_if.out_valid, u_if.in_ready, exp_last.r);
        mismatched++;
      end
    end
    u_if.out_ready = 1'b1;
    send("b2b_or", 3'd1, 64'd1, 64'd2);
    wait_result("b2b_or", 4);
    compared++;
    if (exp_last.r !== 64'h3) begin
      $display("FAIL b2b_or model: got %h want 3", exp_last.r);
      mismatched++;
    end
  endtask

  task automatic test_abort();
    bit spurious = 0;
    @(negedge clk);
    @(negedge clk);
    send("abort", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    compared++;
    if (u_if.in_ready !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.result !== 64'd0 ||
        u_if.zero !== 1'b0 || u_if.illegal !== 1'b0) begin
      $display("FAIL abort reset: got rdy=%b ov=%b res=%h z=%b il=%b want 1 0 0 0 0",
               u_if.in_ready, u_if.out_valid, u_if.result, u_if.zero, u_if.illegal);
      mismatched++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0) spurious = 1;
    end
    compared++;
    if (spurious) begin
      $display("FAIL abort spurious out_valid: got 1 want 0");
      mismatched++;
    end
    run_basic("nota_after_abort", 3'd6, 64'd0, 64'h1234);
  endtask

  task automatic test_single_chunk();
    int   cycles = 0;
    bit   seen = 0;
    exp_t e;
    @(negedge clk);
    u_if64.in_valid = 1'b1;
    u_if64.op       = 3'd0;
    u_if64.a        = 64'hDEADBEEF;
    u_if64.b        = 64'hDEADBEEF;
    sb64.push_back(make_exp(3'd0, 64'hDEADBEEF, 64'hDEADBEEF));
    @(posedge clk);
    #1;
    u_if64.in_valid = 1'b0;
    u_if64.a        = 64'h0;
    u_if64.b        = 64'h0;
    while (!seen && cycles < 10) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (u_if64.out_valid === 1'b1) seen = 1;
    end
    compared++;
    if (!seen || cycles !== 1) begin
      $display("FAIL chunk64 latency: got %0d (seen=%b) want 1", cycles, seen);
      mismatched++;
    end
    e = sb64.pop_front();
    compared++;
    if (u_if64.result !== e.r || u_if64.zero !== e.z || u_if64.illegal !== e.il) begin
      $display("FAIL chunk64 result: got %h z=%b il=%b want %h z=%b il=%b",
               u_if64.result, u_if64.zero, u_if64.illegal, e.r, e.z, e.il);
      mismatched++;
    end
  endtask

  initial begin
    u_if.in_valid    = 1'b0;
    u_if.op          = 3'd0;
    u_if.a           = '0;
    u_if.b           = '0;
    u_if.out_ready   = 1'b1;
    u_if64.in_valid  = 1'b0;
    u_if64.op        = 3'd0;
    u_if64.a         = '0;
    u_if64.b         = '0;
    u_if64.out_ready = 1'b1;
    exp_last         = '{r: 64'd0, z: 1'b0, il: 1'b0};

    test_reset();
    test_ops();
    test_back_to_back();
    test_abort();
    test_single_chunk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/logical_unit_iter.md
LOGICAL_UNIT_ITER -- requirements
Module: logical_unit_iter

Interface
REQ-001 Parameter: WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter: CHUNK, default 16, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  operands and op are valid.
REQ-006 Port: in_ready  output  1  unit can accept a new operation.
REQ-007 Port: op  input  3  operation select, encodings in REQ-013.
REQ-008 Port: a  input  WIDTH  operand A.
REQ-009 Port: b  input  WIDTH  operand B.
REQ-010 Port: out_valid  output  1  result and flags are valid.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: result  output  WIDTH; zero  output  1  result==0; illegal  output  1  op was reserved.

Function
REQ-013 op encodings SHALL be: 000 AND, 001 OR, 010 XOR, 011 ANDN (a&~b), 100 ORN (a|~b), 101 XNOR, 110 NOTA (~a, b ignored), 111 reserved.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-016 Accept occurs on a rising edge with in_valid&&in_ready; at accept, a, b and op SHALL be captured into internal registers, the chunk counter cleared, and the state set to BUSY.
REQ-017 In BUSY, each cycle SHALL compute chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) from the captured operands into the result register, k ascending from 0.
REQ-018 After chunk N-1 (N=WIDTH/CHUNK), the state SHALL become DONE; out_valid SHALL rise exactly N cycles after the accept edge.
REQ-019 zero SHALL be accumulated per chunk and SHALL be valid together with out_valid.
REQ-020 Reserved op SHALL produce result=0, zero=1, illegal=1 with the same latency; legal ops SHALL give illegal=0.
REQ-021 In DONE, result, zero and illegal SHALL be held stable until out_valid&&out_ready.
REQ-022 In DONE with out_ready=1 and in_valid=0, the next state SHALL be IDLE.
REQ-023 In DONE with out_ready=1 and in_valid=1, the new operation SHALL be accepted on the same edge (back-to-back, no bubble), with a next state of BUSY.
REQ-024 Inputs a, b and op SHALL be ignored outside accept edges; changes while BUSY SHALL NOT affect the result.
REQ-025 CHUNK==WIDTH SHALL give a single BUSY cycle (latency 1).

Reset
REQ-026 On rst assertion, regardless of clock, the state SHALL go to IDLE and out_valid, result, zero, illegal and the chunk counter SHALL all go to 0.
REQ-027 rst asserted mid-BUSY or in DONE SHALL abort the operation, and no out_valid SHALL follow for it.
REQ-028 in_ready SHALL read 1 during and after reset, since the state is IDLE.

Structure
REQ-029 A shared package logical_unit_pkg SHALL hold the op encodings, the FSM state typedef, and the default WIDTH and CHUNK values.
REQ-030 A combinational sub-module logical_chunk (CHUNK-bit a, b, op -> CHUNK-bit y) SHALL implement the per-chunk function and be instantiated once.
REQ-031 The chunk counter width SHALL be clog2(N), minimum 1.

Verification
REQ-032 WIDTH=64, CHUNK=16; a=0xFFFF0000FFFF0000, b=0x0F0F0F0F0F0F0F0F, op=XOR -> out_valid 4 cycles after accept, result=0xF0F00F0FF0F00F0F, zero=0.
REQ-033 a=0x00000000000000FF, b=0x00000000000000FF, op=ANDN -> result=0, zero=1, illegal=0.
REQ-034 op=111, arbitrary a and b -> result=0, zero=1, illegal=1, latency 4.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result stable and in_ready=0; then out_ready=1 with in_valid=1 (op=OR, a=1, b=2) -> same-edge accept, next result=0x3.
REQ-036 rst pulsed after 2 BUSY cycles -> immediate IDLE, all outputs 0, no spurious out_valid; the next operation (op=NOTA, a=0) gives result=0xFFFFFFFFFFFFFFFF.
REQ-037 CHUNK=64 build; op=AND, a=b=0xDEADBEEF -> out_valid 1 cycle after accept, result=0xDEADBEEF.
